// File: rtl/mem_ftch_rsp_buf.sv
// rtl/mem_ftch_rsp_buf.sv - in-order memory-to-fetch response buffer with flush
module mem_ftch_rsp_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  count,
    output logic [15:0]       drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  err_mem;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             accept;
    logic             push;
    logic             pop;
    logic [16:0]      drop_sum;
    logic [15:0]      drop_next;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !flush;
    assign pop       = out_valid && out_ready && !flush;

    assign out_addr = addr_mem[rd_ptr];
    assign out_data = data_mem[rd_ptr];
    assign out_err  = err_mem[rd_ptr];

    // A flushed same-cycle offer counts as dropped too; one spare bit catches saturation.
    assign drop_sum  = {1'b0, drop_cnt} + 17'(count) + 17'(accept);
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
            err_mem[wr_ptr]  <= in_err;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            count    <= '0;
            rd_ptr   <= wr_ptr;
            drop_cnt <= drop_next;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ftch_rsp_buf.sv
// tb/tb_mem_ftch_rsp_buf.sv - scoreboard bench for mem_ftch_rsp_buf
module tb_mem_ftch_rsp_buf;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_err;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic [CNT_W-1:0]  count;
    logic [15:0]       drop_cnt;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mem_ftch_rsp_buf #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_err(in_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_err(out_err),
        .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and record it as expected; whether it lands is up to the caller's timing.
    task automatic offer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic e);
        rsp_t r;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_err   = e;
        r.addr = a;
        r.data = d;
        r.err  = e;
        exp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (resetn && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got addr 0x%0h expected no output", out_addr);
            end else begin
                rsp_t r;
                r = exp_q.pop_front();
                check("pop_addr", 64'(out_addr), 64'(r.addr));
                check("pop_data", 64'(out_data), 64'(r.data));
                check("pop_err",  64'(out_err),  64'(r.err));
            end
        end
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_addr = '0; in_data = '0; in_err = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_count",     64'(count),     64'd0);
        check("rst_drop_cnt",  64'(drop_cnt),  64'd0);
        tick();
        resetn = 1'b1;
        tick();

        // single push then pop
        offer(32'h1000, 32'hDEADBEEF, 1'b0);
        tick();
        in_valid = 1'b0;
        check("single_count1", 64'(count), 64'd1);
        check("single_valid",  64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_count0", 64'(count), 64'd0);

        // fill to full, hold the fifth beat, release one slot
        for (int i = 0; i < 4; i++) begin
            offer(32'(i * 4), 32'(i * 4) ^ 32'hA5A50000, 1'(i));
            tick();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        offer(32'h10, 32'h10 ^ 32'hA5A50000, 1'b0);
        tick();
        check("held_count", 64'(count), 64'd4);
        check("held_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("freed_in_ready", 64'(in_ready), 64'd1);
        check("freed_count", 64'(count), 64'd3);
        tick();
        in_valid = 1'b0;
        check("fifth_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("drain_count", 64'(count), 64'd0);

        // sustained push and pop across pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            offer(32'h2000 + 32'(i * 4), 32'(i), 1'b0);
            tick();
            check("stream_count", 64'(count), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_drain", 64'(count), 64'd0);

        // flush with three buffered and one offered
        for (int i = 0; i < 3; i++) begin
            offer(32'h2800 + 32'(i), 32'h0, 1'b1);
            tick();
        end
        exp_q.delete();
        flush = 1'b1;
        in_valid = 1'b1;
        in_addr = 32'h2900;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_drop", 64'(drop_cnt), 64'd4);
        offer(32'h3000, 32'hCAFE0001, 1'b1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // drive drop_cnt to 0xFFFE one dropped offer per cycle
        flush = 1'b1;
        in_valid = 1'b1;
        repeat (65530) @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("preload_drop", 64'(drop_cnt), 64'hFFFE);
        for (int i = 0; i < 3; i++) begin
            offer(32'h3100 + 32'(i), 32'h0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        exp_q.delete();
        flush = 1'b1;
        tick();
        check("sat_drop", 64'(drop_cnt), 64'hFFFF);
        in_valid = 1'b1;
        repeat (2) tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("sat_hold", 64'(drop_cnt), 64'hFFFF);

        // asynchronous reset between edges with two entries held
        for (int i = 0; i < 2; i++) begin
            offer(32'h3800 + 32'(i), 32'h0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 64'(count), 64'd2);
        #2;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_drop", 64'(drop_cnt), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        offer(32'h4000, 32'h0BADF00D, 1'b1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("final_count", 64'(count), 64'd0);

        repeat (2) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ftch_rsp_buf.md
# mem_ftch_rsp_buf

Parametrised response buffer between the memory port and the fetch stage. It carries the mem_ftch packet contents (address, instruction data, error flag) but adds the valid/ready back-pressure, multi-entry buffering and flush that the single-cycle mem_ftch packet path does not have. Memory pushes responses in, and fetch pops them in order. A flush from fetch (redirect or branch) discards every buffered response.

## Interface
Parameters:
- ADDR_W, 32, width of the fetch address carried with each response
- DATA_W, 32, width of the instruction data word
- DEPTH, 4, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  reset, asynchronous assert, active-low
- flush  in  1  discard all buffered entries and any same-cycle push
- in_valid  in  1  memory offers a response
- in_ready  out  1  buffer accepts a response this cycle
- in_addr  in  ADDR_W  fetch address of the response
- in_data  in  DATA_W  instruction word
- in_err  in  1  memory access error flag
- out_valid  out  1  head entry valid
- out_ready  in  1  fetch consumes the head this cycle
- out_addr  out  ADDR_W  head address
- out_data  out  DATA_W  head data
- out_err  out  1  head error flag
- count  out  CNT_W  current occupancy
- drop_cnt  out  16  saturating total of entries discarded by flush

## Operation
- Circular storage with read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits wide and wrapping modulo DEPTH. Occupancy is held in count.
- Push = in_valid && in_ready && !flush. The entry is written at wr_ptr, then wr_ptr increments.
- Pop = out_valid && out_ready && !flush. rd_ptr increments.
- in_ready = (count != DEPTH). This is combinational from registered state only; it does not depend on out_ready, so there is no pass-through when the buffer is full.
- out_valid = (count != 0). out_addr, out_data and out_err are the entry at rd_ptr. Their value is don't-care when out_valid = 0.
- Count update:
  - push only: count + 1
  - pop only: count − 1
  - push and pop together: count unchanged, both pointers advance
- Flush has priority over push and pop. On the next edge:
  - count ← 0
  - rd_ptr ← wr_ptr
  - drop_cnt ← min(drop_cnt + count + (in_valid && in_ready), 16'hFFFF)
  - No entry is written or consumed in the flush cycle.
- drop_cnt saturates at 16'hFFFF, never wraps, and is cleared only by reset.
- Storage contents are not reset. Only pointers, count and drop_cnt are reset.

## Timing
- Reset (resetn = 0, asynchronous): count = 0, drop_cnt = 0, rd_ptr = wr_ptr = 0. As a result out_valid = 0 and in_ready = 1 immediately, without waiting for a clock edge.
- Reset asserted mid-operation drops every entry without incrementing drop_cnt.
- Latency: an entry pushed at edge N is visible on out_* with out_valid = 1 after edge N. Minimum push-to-pop latency is one cycle. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle, sustained, at any occupancy from 1 to DEPTH−1.
- Full (count = DEPTH): in_ready = 0. A pop in this cycle frees the slot, and in_ready = 1 from the next cycle.
- Empty (count = 0): out_valid = 0. out_ready is ignored.
- Pointer wrap: after index DEPTH−1 the pointer moves to 0, and ordering is preserved across the wrap.
- Handshake rules the upstream and downstream sides must follow:
  - Memory must hold in_* stable while in_valid && !in_ready.
  - The buffer holds out_* stable while out_valid && !out_ready, except across a flush.

## Test plan
- Reset then a single push of addr 0x1000, data 0xDEADBEEF, err 0 → out_valid = 1 one cycle later with identical fields; count goes 0 → 1 → 0 after the pop.
- Fill with out_ready = 0 and DEPTH = 4 (addrs 0x0, 0x4, 0x8, 0xC) → count = 4, in_ready = 0, and a 5th push is held. Pop one → in_ready = 1 next cycle, the 5th push is accepted, and pops return 0x4, 0x8, 0xC, 0x10 in order.
- Continuous push and pop for 3×DEPTH cycles with incrementing data → count is constant at 1 after the first cycle, no bubbles, and data is in order across pointer wrap.
- Three entries buffered, then flush with in_valid = 1 and in_ready = 1 → next cycle count = 0, out_valid = 0, drop_cnt = 4, and no entry from the flush cycle appears.
- Preload drop_cnt to 16'hFFFE via repeated flushes, then flush with 3 entries → drop_cnt = 16'hFFFF and stays there on further flushes.
- Assert resetn = 0 asynchronously between edges with 2 entries buffered → out_valid falls and in_ready rises without a clock edge, drop_cnt = 0, and the first push after reset is popped correctly.
